// File: rtl/sdram_traffic_gen.sv
// Traffic generator and checker for the sdram_top command port.
// It runs a write pass over NUM_OPS locations, then a read-back pass over the
// same locations. Each read is compared against data regenerated from a
// reseeded LFSR.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for start
// S_W_ISSUE | sel strobe for a write, addr/in_data valid
// S_W_WAIT  | write outstanding, waiting for ready or timeout
// S_R_ISSUE | sel strobe for a read, in_data = 0
// S_R_WAIT  | read outstanding, compare out_data on ready
// S_DONE    | one-cycle done pulse with pass verdict
module sdram_traffic_gen #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          NUM_OPS   = 8,
  parameter logic [13:0] ROW_BASE  = 14'd0,
  parameter logic [31:0] DATA_SEED = 32'hACE1_2345,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              write,
  output logic              sel,
  output logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] out_data,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [8:0]        first_err_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_ISSUE, S_W_WAIT, S_R_ISSUE, S_R_WAIT, S_DONE
  } state_t;

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [8:0]  LAST_IDX  = 9'(NUM_OPS - 1);
  // Galois mask for x^32 + x^22 + x^2 + x + 1, right-shifting form.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  state_t          state;
  logic [1:0]      mode_q;
  logic [8:0]      idx;
  logic [31:0]     lfsr;
  logic [TW-1:0]   tmo_cnt;

  logic [8:0]      idx_nxt;
  logic [31:0]     lfsr_nxt;
  logic            mismatch;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'd0);
  endfunction

  // Mode 3 is reserved and falls through to the sequential-column layout.
  function automatic logic [ADDR_W-1:0] op_addr(input logic [1:0] m, input logic [8:0] n);
    logic [8:0]        col;
    logic [1:0]        bank;
    logic [13:0]       row;
    logic [ADDR_W-1:0] a;
    col  = 9'd0;
    bank = 2'd0;
    row  = ROW_BASE;
    case (m)
      2'd1: begin
        bank = n[1:0];
        col  = {2'b00, n[8:2]};
      end
      2'd2:    row = ROW_BASE + {5'd0, n};
      default: col = n;
    endcase
    a       = '0;
    a[24:0] = {col, bank, row};
    return a;
  endfunction

  // Next-op index, next data word and read compare for the current op.
  always_comb begin
    idx_nxt  = idx + 9'd1;
    lfsr_nxt = lfsr_step(lfsr);
    mismatch = (out_data != lfsr[DATA_W-1:0]);
  end

  // Sequencer with registered command and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= 2'd0;
      idx           <= 9'd0;
      lfsr          <= DATA_SEED;
      tmo_cnt       <= '0;
      write         <= 1'b0;
      sel           <= 1'b0;
      in_data       <= '0;
      addr          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= 16'd0;
      first_err_idx <= 9'd0;
    end else begin
      sel  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q        <= mode;
            err_count     <= 16'd0;
            first_err_idx <= 9'd0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
            idx           <= 9'd0;
            lfsr          <= DATA_SEED;
            busy          <= 1'b1;
            write         <= 1'b1;
            sel           <= 1'b1;
            addr          <= op_addr(mode, 9'd0);
            in_data       <= DATA_SEED[DATA_W-1:0];
            state         <= S_W_ISSUE;
          end
        end
        S_W_ISSUE: begin
          tmo_cnt <= TW'(TIMEOUT - 1);
          state   <= S_W_WAIT;
        end
        S_W_WAIT: begin
          if (ready) begin
            sel <= 1'b1;
            if (idx == LAST_IDX) begin
              idx     <= 9'd0;
              lfsr    <= DATA_SEED;
              write   <= 1'b0;
              addr    <= op_addr(mode_q, 9'd0);
              in_data <= '0;
              state   <= S_R_ISSUE;
            end else begin
              idx     <= idx_nxt;
              lfsr    <= lfsr_nxt;
              addr    <= op_addr(mode_q, idx_nxt);
              in_data <= lfsr_nxt[DATA_W-1:0];
              state   <= S_W_ISSUE;
            end
          end else if (tmo_cnt == '0) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            write   <= 1'b0;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_R_ISSUE: begin
          tmo_cnt <= TW'(TIMEOUT - 1);
          state   <= S_R_WAIT;
        end
        S_R_WAIT: begin
          if (ready) begin
            if (mismatch) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              if (err_count == 16'd0) first_err_idx <= idx;
            end
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mismatch && (err_count == 16'd0);
              state <= S_DONE;
            end else begin
              idx   <= idx_nxt;
              lfsr  <= lfsr_nxt;
              sel   <= 1'b1;
              addr  <= op_addr(mode_q, idx_nxt);
              state <= S_R_ISSUE;
            end
          end else if (tmo_cnt == '0) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Bench for sdram_traffic_gen: behavioural SDRAM responder, op monitor and
// arithmetic reference model for addresses and data.
module tb_sdram_traffic_gen;

  localparam int          NOPS = 8;
  localparam int          TMO  = 16;
  localparam logic [13:0] RB   = 14'h3FFD;
  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        write;
  logic        sel;
  logic [31:0] in_data;
  logic [31:0] addr;
  logic [31:0] out_data;
  logic        ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] err_count;
  logic [8:0]  first_err_idx;

  sdram_traffic_gen #(
    .DATA_W(32), .ADDR_W(32), .NUM_OPS(NOPS), .ROW_BASE(RB),
    .DATA_SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .write(write), .sel(sel),
    .in_data(in_data), .addr(addr), .out_data(out_data), .ready(ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: addresses and data computed from the addressing rules.
  function automatic logic [31:0] model_addr(input int m, input int i);
    int col, bank, row;
    col = 0; bank = 0; row = int'(RB);
    if (m == 1) begin
      bank = i % 4;
      col  = i / 4;
    end else if (m == 2) begin
      row = (int'(RB) + i) % 16384;
    end else begin
      col = i;
    end
    return 32'(col * 65536 + bank * 16384 + row);
  endfunction

  function automatic logic [31:0] model_data(input int i);
    logic [31:0] v;
    v = SEED;
    for (int k = 0; k < i; k++) v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    return v;
  endfunction

  // Responder: memory model with configurable latency, hang and read corruption.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] flip [NOPS];
  int          resp_delay  = 3;
  int          hang_wr     = -1;
  bit          ready_const = 1'b0;
  int          cnt         = 0;
  int          wr_n        = 0;
  int          rd_n        = 0;

  initial begin
    ready    = 1'b0;
    out_data = 32'h0;
  end

  always @(negedge clk) begin
    if (rst) begin
      cnt   = 0;
      ready = 1'b0;
    end else begin
      if (ready_const) ready = 1'b1;
      else begin
        ready = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) ready = 1'b1;
        end
      end
      if (sel) begin
        if (write) begin
          mem[addr] = in_data;
          cnt = (wr_n == hang_wr) ? 0 : resp_delay;
          wr_n++;
        end else begin
          out_data = (mem.exists(addr) ? mem[addr] : 32'h0) ^ flip[rd_n % NOPS];
          cnt = resp_delay;
          rd_n++;
        end
      end
    end
  end

  // Monitor: records each issued op and the status seen at each done pulse.
  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } op_t;

  op_t         ops[$];
  op_t         last_op;
  int          sel_cnt  = 0;
  int          rd_iss   = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        d_pass, d_tmo, d_busy;
  logic [15:0] d_err;
  logic [8:0]  d_first;

  always @(negedge clk) begin
    if (!rst) begin
      if (sel) begin
        last_op = '{wr: write, a: addr, d: in_data, c: cyc};
        ops.push_back(last_op);
        sel_cnt++;
        if (!write) rd_iss++;
      end else if (busy) begin
        check("hold_in_wait", {write, addr, in_data}, {last_op.wr, last_op.a, last_op.d});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        d_pass   = pass;
        d_tmo    = timeout;
        d_busy   = busy;
        d_err    = err_count;
        d_first  = first_err_idx;
      end
    end
  end

  task automatic clear_flips();
    for (int k = 0; k < NOPS; k++) flip[k] = 32'h0;
  endtask

  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    sel_cnt  = 0;
    rd_iss   = 0;
    done_cnt = 0;
    ops.delete();
    wr_n     = 0;
    rd_n     = 0;
    cnt      = 0;
    mode     = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_done_wait: got no done, expected done within 3000 cycles", nm);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_ops(input string nm, input int m, input int nwr, input int nrd);
    int i;
    bit wr;
    check($sformatf("%s_nops", nm), 96'(ops.size()), 96'(nwr + nrd));
    for (int k = 0; k < ops.size() && k < nwr + nrd; k++) begin
      wr = (k < nwr);
      i  = wr ? k : k - nwr;
      check($sformatf("%s_op%0d", nm, k), {ops[k].wr, ops[k].a, ops[k].d},
            {wr, model_addr(m, i), wr ? model_data(i) : 32'h0});
    end
  endtask

  task automatic run_and_check(input string nm, input logic [1:0] m, input int dly,
                               input int e_err, input int e_first, input bit e_pass);
    resp_delay = dly;
    do_start(m);
    wait_done(nm);
    check($sformatf("%s_done_cnt", nm), 96'(done_cnt), 96'd1);
    check($sformatf("%s_sel_cnt", nm), 96'(sel_cnt), 96'(2 * NOPS));
    check_ops(nm, int'(m), NOPS, NOPS);
    check($sformatf("%s_status", nm), {d_pass, d_tmo, d_busy, d_err, d_first},
          {e_pass, 1'b0, 1'b0, 16'(e_err), 9'(e_first)});
    check($sformatf("%s_err_hold", nm), {err_count, first_err_idx}, {16'(e_err), 9'(e_first)});
  endtask

  typedef struct {
    logic [1:0]  m;
    int          dly;
    int          ia;
    logic [31:0] fa;
    int          ib;
    logic [31:0] fb;
    int          e_err;
    int          e_first;
    bit          e_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          e_err, e_first;
    logic [31:0] outs_zero;

    vecs[0] = '{2'd0, 3, 0, 32'h0,        0, 32'h0,        0, 0, 1'b1};
    vecs[1] = '{2'd1, 3, 0, 32'h0,        0, 32'h0,        0, 0, 1'b1};
    vecs[2] = '{2'd0, 3, 5, 32'h1,        6, 32'h8000_0000, 2, 5, 1'b0};
    vecs[3] = '{2'd2, 1, 0, 32'h0,        0, 32'h0,        0, 0, 1'b1};
    vecs[4] = '{2'd3, 2, 0, 32'h0,        0, 32'h0,        0, 0, 1'b1};
    vecs[5] = '{2'd1, 4, 6, 32'h0001_0000, 6, 32'h0,       1, 6, 1'b0};

    rst = 1'b1; start = 1'b0; mode = 2'd0;
    clear_flips();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {write, sel, in_data, addr, busy, done, pass, timeout, err_count, first_err_idx},
          '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clear_flips();
      flip[vecs[v].ia] = flip[vecs[v].ia] | vecs[v].fa;
      flip[vecs[v].ib] = flip[vecs[v].ib] | vecs[v].fb;
      run_and_check($sformatf("vec%0d", v), vecs[v].m, vecs[v].dly,
                    vecs[v].e_err, vecs[v].e_first, vecs[v].e_pass);
    end
    clear_flips();

    // Timeout on write #2: no read may be issued.
    hang_wr    = 2;
    resp_delay = 3;
    do_start(2'd0);
    wait_done("tmo");
    check("tmo_status", {d_pass, d_tmo, d_busy}, {1'b0, 1'b1, 1'b0});
    check_ops("tmo", 0, 3, 0);
    check("tmo_no_read", 96'(rd_iss), 96'd0);
    if (ops.size() >= 3)
      check("tmo_latency", 96'(done_cyc - ops[2].c), 96'(TMO + 1));
    repeat (3) @(negedge clk);
    check("tmo_sticky", {timeout, busy}, {1'b1, 1'b0});
    hang_wr = -1;
    run_and_check("after_tmo", 2'd0, 2, 0, 0, 1'b1);

    // Reset in the wait phase of read #3, then a clean pass.
    resp_delay = 3;
    do_start(2'd1);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rd_iss == 4 && !sel) break;
    end
    check("mid_rst_reached", {rd_iss[7:0], sel, write, busy}, {8'd4, 1'b0, 1'b0, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    outs_zero = 32'h0;
    check("mid_rst_outputs",
          {write, sel, in_data, addr, busy, done, pass, timeout, err_count, first_err_idx},
          {1'b0, 1'b0, outs_zero, outs_zero, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 9'h0});
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_and_check("after_rst", 2'd1, 3, 0, 0, 1'b1);

    // Ready held high: 2 cycles per op, start while busy ignored.
    ready_const = 1'b1;
    do_start(2'd0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("rc");
    repeat (10) @(negedge clk);
    check("rc_done_cnt", 96'(done_cnt), 96'd1);
    check("rc_sel_cnt", 96'(sel_cnt), 96'(2 * NOPS));
    check_ops("rc", 0, NOPS, NOPS);
    begin
      int bad;
      bad = 0;
      for (int k = 1; k < ops.size(); k++) if (ops[k].c - ops[k-1].c != 2) bad++;
      check("rc_interval", 96'(bad), 96'd0);
    end
    if (ops.size() > 0) check("rc_total", 96'(done_cyc - ops[0].c), 96'(4 * NOPS));
    check("rc_status", {d_pass, d_tmo, d_err}, {1'b1, 1'b0, 16'h0});
    ready_const = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized runs against the reference model.
    for (int r = 0; r < 6; r++) begin
      logic [1:0] m;
      int         dly, nf, k;
      m   = 2'($urandom_range(0, 3));
      dly = int'($urandom_range(1, 4));
      nf  = int'($urandom_range(0, 3));
      clear_flips();
      for (int f = 0; f < nf; f++) begin
        k = int'($urandom_range(0, NOPS - 1));
        flip[k] = $urandom() | 32'h1;
      end
      e_err   = 0;
      e_first = 0;
      for (int j = NOPS - 1; j >= 0; j--) begin
        if (flip[j] != 32'h0) begin
          e_err++;
          e_first = j;
        end
      end
      run_and_check($sformatf("rnd%0d", r), m, dly, e_err, e_first, (e_err == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_traffic_gen.md
Name: sdram_traffic_gen

Overview:
Synthesizable, parametrised traffic generator/checker that drives sdram_top's command port (write/sel/in_data/addr, ready/out_data). It runs a programmable write pass and then a read-back pass over NUM_OPS locations, comparing each read against regenerated expected data. It adds addressing modes, pseudo-random data, a completion timeout and error reporting, and serves as an on-chip self-test and regression master.

Parameters:
DATA_W, 32, data bus width (2..32 bits; data LFSR uses the low DATA_W bits)
ADDR_W, 32, address bus width (>=25)
NUM_OPS, 8, writes per pass; the read pass issues the same count (1..512)
ROW_BASE, 0, 14-bit row used in modes 0/1
DATA_SEED, 32'hACE1_2345, data LFSR seed (nonzero)
TIMEOUT, 1024, max cycles waiting for ready per op

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, accepted only in IDLE
mode  in  2  0=sequential column, 1=bank-interleave, 2=row-walk, 3=reserved (treated as 0)
write  out  1  operation type to sdram_top (1=write)
sel  out  1  one-cycle request strobe
in_data  out  DATA_W  write data
addr  out  ADDR_W  {unused, col[24:16], bank[15:14], row[13:0]}
out_data  in  DATA_W  read data from sdram_top
ready  in  1  operation complete
busy  out  1  high from start acceptance until DONE
done  out  1  one-cycle pulse on test end
pass  out  1  valid at done: err_count==0 and no timeout
timeout  out  1  sticky until next start/rst
err_count  out  16  read mismatches, saturating at 16'hFFFF
first_err_idx  out  9  index of first mismatching read

Behaviour:
- Reset: all outputs 0; FSM in IDLE; op index i=0; data LFSR = DATA_SEED.
- FSM: IDLE -> W_ISSUE -> W_WAIT -> (W_ISSUE | R_ISSUE) ; R_ISSUE -> R_WAIT -> (R_ISSUE | DONE) ; DONE -> IDLE.
- IDLE + start: latch mode, clear err_count/first_err_idx/timeout, i=0, reseed LFSR, busy=1, write=1.
- ISSUE state (1 cycle): sel=1; addr/in_data driven (in_data=0 on reads); write=1 in W_*, 0 in R_*; addr, in_data and write held stable through the following WAIT state.
- WAIT: sel=0. The ISSUE cycle never counts as completion; the first WAIT-state cycle with ready=1 completes the op. i increments; LFSR advances once per completed op.
- Address for op i: mode0 col=i, bank=0, row=ROW_BASE; mode1 bank=i[1:0], col=i>>2, row=ROW_BASE; mode2 row=ROW_BASE+i (mod 2^14), bank=0, col=0. Bits above 24 are 0.
- Write data = current LFSR value (32-bit Galois, taps x^32+x^22+x^2+x+1, truncated to DATA_W).
- Write->read turnaround: after the last write completes (i==NUM_OPS-1), i=0, LFSR reseeded, write=0; the read pass reproduces the same address/data sequence.
- Read check: on the completing cycle, compare out_data to the LFSR value. On mismatch, err_count += 1 (saturating); first_err_idx = i only if err_count was 0.
- Timeout: a per-op counter clears on ISSUE; if TIMEOUT cycles pass in WAIT without ready, set timeout=1 and go to DONE immediately (remaining ops skipped).
- DONE (1 cycle): done=1, busy=0, pass computed; return to IDLE. err_count, first_err_idx and timeout hold until the next start.
- start outside IDLE is ignored. rst mid-test returns every output to its reset value within one cycle, with sel=0 on the next edge.
- ready seen while in ISSUE or IDLE is ignored.

Test Plan:
- Ideal model, ready 3 cycles after sel, mode0, NUM_OPS=8 -> 8 writes to col 0..7 then 8 reads; done with pass=1, err_count=0; total sel pulses =16.
- Mode1 -> write addrs: bank 0,1,2,3,0,1,2,3 and col 0,0,0,0,1,1,1,1; read addresses repeat in identical order.
- Model corrupts read #5 (bit0 flipped) and read #6 -> err_count=2, first_err_idx=5, pass=0.
- ready never asserted on write #2, TIMEOUT=16 -> done 16 cycles into that WAIT; timeout=1, pass=0, no read sel issued.
- rst asserted during R_WAIT of read #3 -> next cycle all outputs 0, FSM IDLE; a new start runs a clean full pass with pass=1.
- ready held high constantly -> each op takes exactly 2 cycles (ISSUE+WAIT); a start pulse while busy is ignored (single done pulse).
